// File: rtl/ebi_slave_pkg.sv
// Shared definitions for the EBI slave and the register file behind it:
// bus width defaults, FSM state encoding and a saturating counter helper.
package ebi_slave_pkg;

    localparam int EBI_ADDR_WIDTH = 21;
    localparam int EBI_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_PULSE     = 3'd1,
        ST_RD_PULSE     = 3'd2,
        ST_RD_CAPTURE   = 3'd3,
        ST_RD_DRIVE     = 3'd4,
        ST_WAIT_RELEASE = 3'd5
    } ebi_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ebi_slave_if.sv
// Bundle of the MCU-facing EBI pins and the register-file side port.
interface ebi_slave_if
    import ebi_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = EBI_ADDR_WIDTH,
    parameter int DATA_WIDTH = EBI_DATA_WIDTH
) ();

    logic                  ebi_cs;
    logic                  ebi_wr;
    logic                  ebi_rd;
    logic [ADDR_WIDTH-1:0] ebi_addr;
    logic [DATA_WIDTH-1:0] ebi_data_in;
    logic [DATA_WIDTH-1:0] ebi_data_out;
    logic                  ebi_data_oe;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic                  reg_we;
    logic                  reg_re;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic [7:0]            err_count;

    modport slave (
        input  ebi_cs, ebi_wr, ebi_rd, ebi_addr, ebi_data_in, reg_rdata,
        output ebi_data_out, ebi_data_oe, reg_addr, reg_wdata, reg_we, reg_re, err_count
    );

    modport master (
        output ebi_cs, ebi_wr, ebi_rd, ebi_addr, ebi_data_in, reg_rdata,
        input  ebi_data_out, ebi_data_oe, reg_addr, reg_wdata, reg_we, reg_re, err_count
    );

endinterface

// File: rtl/ebi_slave_sync2.sv
// sync2: single-bit two-flop synchronizer for the asynchronous EBI strobes.
module ebi_slave_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ebi_slave.sv
// EBI slave: turns asynchronous MCU chip-select/strobe cycles into single
// register-file read/write pulses and drives read data back to the pad.
module ebi_slave
    import ebi_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = EBI_ADDR_WIDTH,
    parameter int DATA_WIDTH = EBI_DATA_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    ebi_slave_if.slave bus
);

    logic w_cs, w_wr, w_rd;

    ebi_slave_sync2 u_sync2_cs (.clk(clk), .rst_n(reset), .i_d(bus.ebi_cs), .o_q(w_cs));
    ebi_slave_sync2 u_sync2_wr (.clk(clk), .rst_n(reset), .i_d(bus.ebi_wr), .o_q(w_wr));
    ebi_slave_sync2 u_sync2_rd (.clk(clk), .rst_n(reset), .i_d(bus.ebi_rd), .o_q(w_rd));

    ebi_state_t            r_state, w_next_state;
    logic                  r_we, r_re, r_oe, r_stb_d;
    logic [1:0]            r_warm;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [7:0]            r_err;

    logic w_we, w_re, w_oe, w_load_addr, w_load_wdata, w_capture, w_err_inc;
    logic w_stray;

    // A strobe edge seen while chip select is low is a protocol violation.
    assign w_stray = (w_wr | w_rd) & ~r_stb_d & ~w_cs;

    // Next-state and next-output decode. r_warm keeps the FSM quiet until the
    // synchronizers reflect the real pins after reset; the first look at cs
    // then parks in WAIT_RELEASE if a cycle was already in flight.
    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_re         = 1'b0;
        w_oe         = 1'b0;
        w_load_addr  = 1'b0;
        w_load_wdata = 1'b0;
        w_capture    = 1'b0;
        w_err_inc    = w_stray;
        case (r_state)
            ST_IDLE: begin
                if (r_warm == 2'd2) begin
                    if (w_cs) w_next_state = ST_WAIT_RELEASE;
                end else if (r_warm == 2'd3) begin
                    if (w_cs && w_wr) begin
                        w_next_state = ST_WR_PULSE;
                        w_we         = 1'b1;
                        w_load_addr  = 1'b1;
                        w_load_wdata = 1'b1;
                        if (w_rd) w_err_inc = 1'b1;
                    end else if (w_cs && w_rd) begin
                        w_next_state = ST_RD_PULSE;
                        w_re         = 1'b1;
                        w_load_addr  = 1'b1;
                    end
                end
            end
            ST_WR_PULSE:   w_next_state = ST_WAIT_RELEASE;
            ST_RD_PULSE:   w_next_state = ST_RD_CAPTURE;
            ST_RD_CAPTURE: begin
                w_next_state = ST_RD_DRIVE;
                w_capture    = 1'b1;
                w_oe         = 1'b1;
            end
            ST_RD_DRIVE: begin
                if (w_cs && w_rd) begin
                    w_oe = 1'b1;
                end else begin
                    // Still-selected but rd dropped: wait out cs so a second
                    // rd under the same cs cannot start another read.
                    w_next_state = w_cs ? ST_WAIT_RELEASE : ST_IDLE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!w_cs) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, pulse and data registers; every output comes straight from here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_oe    <= 1'b0;
            r_stb_d <= 1'b0;
            r_warm  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_err   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_we    <= w_we;
            r_re    <= w_re;
            r_oe    <= w_oe;
            r_stb_d <= w_wr | w_rd;
            if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
            if (w_load_addr)    r_addr  <= bus.ebi_addr;
            if (w_load_wdata)   r_wdata <= bus.ebi_data_in;
            if (w_capture)      r_dout  <= bus.reg_rdata;
            if (w_err_inc)      r_err   <= sat_inc8(r_err);
        end
    end

    assign bus.reg_we       = r_we;
    assign bus.reg_re       = r_re;
    assign bus.reg_addr     = r_addr;
    assign bus.reg_wdata    = r_wdata;
    assign bus.ebi_data_out = r_dout;
    assign bus.ebi_data_oe  = r_oe;
    assign bus.err_count    = r_err;

endmodule

// File: doc/ebi_slave.md
EBI_SLAVE -- requirements
Module: ebi_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 21, EBI address width.
REQ-002 Parameter DATA_WIDTH, default 16, EBI data width.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ebi_cs  input  1  chip select from MCU, asynchronous to clk, active-high.
REQ-006 ebi_wr  input  1  write strobe from MCU, asynchronous, active-high.
REQ-007 ebi_rd  input  1  read strobe from MCU, asynchronous, active-high.
REQ-008 ebi_addr  input  ADDR_WIDTH  address from MCU, quasi-static.
REQ-009 ebi_data_in  input  DATA_WIDTH  write data from the pad.
REQ-010 ebi_data_out  output  DATA_WIDTH  read data to the pad.
REQ-011 ebi_data_oe  output  1  pad output enable; the tristate buffer lives at top level.
REQ-012 reg_addr  output  ADDR_WIDTH  register-file address.
REQ-013 reg_wdata  output  DATA_WIDTH  register-file write data.
REQ-014 reg_we  output  1  one-cycle write pulse.
REQ-015 reg_re  output  1  one-cycle read pulse.
REQ-016 reg_rdata  input  DATA_WIDTH  register-file read data, valid one cycle after reg_re.
REQ-017 err_count  output  8  saturating count of protocol violations.

Function
REQ-018 ebi_cs, ebi_wr and ebi_rd SHALL each pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized copies.
REQ-019 ebi_addr and ebi_data_in SHALL be sampled unsynchronized, and only when the FSM leaves IDLE; the bus master holds them stable from strobe assertion until 2 clk after strobe release.
REQ-020 FSM states: IDLE, WR_PULSE, RD_PULSE, RD_CAPTURE, RD_DRIVE, WAIT_RELEASE.
REQ-021 IDLE with sync cs&wr -> WR_PULSE; latch reg_addr and reg_wdata; this SHALL occur on the 3rd rising edge after raw cs&wr first become high.
REQ-022 WR_PULSE: reg_we=1 for exactly one cycle -> WAIT_RELEASE.
REQ-023 IDLE with sync cs&rd and not wr -> RD_PULSE; latch reg_addr.
REQ-024 RD_PULSE: reg_re=1 for exactly one cycle -> RD_CAPTURE.
REQ-025 RD_CAPTURE: register reg_rdata into ebi_data_out and set ebi_data_oe=1 -> RD_DRIVE.
REQ-026 RD_DRIVE: hold ebi_data_out and keep oe=1 while sync cs&rd; when either drops, clear oe on the next edge -> IDLE.
REQ-027 WAIT_RELEASE: remain while sync cs is high; go to IDLE when sync cs is low. Exactly one reg_we or reg_re SHALL occur per cs assertion.
REQ-028 Simultaneous sync wr&rd in IDLE: treat as write and increment err_count.
REQ-029 Strobe (wr or rd) without cs: ignore and increment err_count once per strobe rising edge.
REQ-030 err_count SHALL saturate at 0xFF and never wrap.
REQ-031 ebi_data_oe SHALL never be high in any state other than RD_DRIVE, and the cycle entering it.
REQ-032 All outputs SHALL be registered; no combinational path from EBI inputs to outputs.

Reset
REQ-033 Reset asserted SHALL immediately and asynchronously force: state=IDLE, synchronizers=0, reg_we=0, reg_re=0, ebi_data_oe=0, ebi_data_out=0, reg_addr=0, reg_wdata=0, err_count=0.
REQ-034 If reset is released mid-transaction with cs still high, the block SHALL enter WAIT_RELEASE and issue no pulse until cs is deasserted.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the ADDR_WIDTH/DATA_WIDTH defaults, for use by the mecobo register file.
REQ-036 A single sub-module, sync2, SHALL implement the 1-bit 2-flop synchronizer and be instantiated three times.

Verification
REQ-037 Write: cs=wr=1 held 4 clk, addr=1, data=0x000F -> exactly one reg_we, with reg_addr=1 and reg_wdata=0x000F, on the 3rd edge after assertion.
REQ-038 Read: addr=1, reg_rdata=0x000F, cs=rd=1 held 6 clk -> one reg_re; oe=1 and ebi_data_out=0x000F from the 5th edge; oe=0 within 3 edges of rd release.
REQ-039 Back-to-back: write 0x1234 to addr 2, release 3 clk, then read addr 2 -> second transaction accepted; one reg_we followed by one reg_re.
REQ-040 Violation: cs=wr=rd=1 -> write performed, err_count=1; then wr pulse with cs=0 -> no reg_we, err_count=2.
REQ-041 Reset mid-read: assert reset during RD_DRIVE -> oe=0 with no clk edge; release with cs high -> no reg_re until cs drops and reasserts.
REQ-042 Saturation: 300 cs-less strobes -> err_count=0xFF.
